huffman_bitstream_feeder: RTL

Controller that sequences the serial Huffman decoder from a byte-wide JPEG entropy-coded stream. Accepts bytes over a valid/ready handshake, removes 0xFF00 byte stuffing, recognises RSTn/EOI markers, and serialises data bits MSB-first into the decoder's `serial_in`/`valid_in`. Throttles on the decoder's buffer occupancy, resets the decoder at restart markers, and counts decoded blocks. Sits between the entropy-segment byte FIFO and `huffman_decoder`.

---
 rtl/huffman_pkg.sv | 22 ++
 rtl/bit_serializer.sv | 33 +++
 rtl/huffman_bitstream_feeder.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/huffman_pkg.sv
// Shared types and JPEG marker constants for the Huffman bitstream feeder.
package huffman_pkg;

    typedef enum logic [2:0] {
        S_FETCH,
        S_CHECK_FF,
        S_SHIFT,
        S_DONE,
        S_ERROR
    } feed_state_t;

    localparam logic [7:0] MARKER_PREFIX = 8'hFF;
    localparam logic [7:0] STUFF_BYTE    = 8'h00;
    localparam logic [7:0] RST0          = 8'hD0;
    localparam logic [7:0] RST7          = 8'hD7;
    localparam logic [7:0] EOI           = 8'hD9;

    function automatic logic is_rst_marker(input logic [7:0] code);
        return (code >= RST0) && (code <= RST7);
    endfunction

endpackage

// File: rtl/bit_serializer.sv
// 8-bit parallel-load, MSB-first shift register that holds while throttled.
// `last` marks the final bit of the loaded byte.
module bit_serializer (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [7:0] data,
    input  logic       shift,
    output logic       msb,
    output logic       last
);

    logic [7:0] shreg;
    logic [3:0] count;

    // NOTE: sequential state is assigned with <= so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shreg <= '0;
            count <= '0;
        end else if (load) begin
            shreg <= data;
            count <= 4'd8;
        end else if (shift && (count != 4'd0)) begin
            shreg <= {shreg[6:0], 1'b0};
            count <= count - 4'd1;
        end
    end

    assign msb  = shreg[7];
    assign last = (count == 4'd1);

endmodule

// File: rtl/huffman_bitstream_feeder.sv
// Byte-stream to serial-bit feeder for the Huffman decoder: unstuffs 0xFF00,
// decodes RSTn/EOI markers, throttles on decoder occupancy, counts blocks.
// Optional statistics counters are built when HUFF_FEED_STATS_EN is defined.
module huffman_bitstream_feeder
    import huffman_pkg::*;
#(
    parameter int FILL_LIMIT = 20,
    parameter int CNT_W      = 16
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic [7:0]       byte_in,
    input  logic             byte_valid_in,
    output logic             byte_ready_out,
    input  logic [4:0]       dec_len_in,
    input  logic             dec_valid_in,
    input  logic             dec_dc_in,
    output logic             serial_out,
    output logic             serial_valid_out,
    output logic             dec_rst_out,
    output logic [7:0]       marker_out,
    output logic             marker_valid_out,
    output logic [CNT_W-1:0] blocks_out,
    output logic             done_out,
    output logic             error_out,
    output logic [23:0]      bits_out,
    output logic [15:0]      stuffed_out
);

    localparam logic [4:0] FILL_LV = 5'(FILL_LIMIT);

    feed_state_t state, next_state;

    logic       take;
    logic       emit;
    logic       load;
    logic [7:0] load_data;
    logic       mark;
    logic       mark_rst;
    logic       set_done;
    logic       set_err;
    logic       ser_msb;
    logic       ser_last;

    assign take = byte_valid_in && byte_ready_out;
    // Throttle looks at the occupancy of this very cycle; the decoder's lag is covered by FILL_LIMIT headroom.
    assign emit = (state == S_SHIFT) && (dec_len_in < FILL_LV);

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) state <= S_FETCH;
        else        state <= next_state;
    end

    // NOTE: every signal driven here gets a default first, so no latch can be inferred.
    always_comb begin
        next_state = state;
        load       = 1'b0;
        load_data  = byte_in;
        mark       = 1'b0;
        mark_rst   = 1'b0;
        set_done   = 1'b0;
        set_err    = 1'b0;
        case (state)
            S_FETCH: begin
                if (take) begin
                    if (byte_in == MARKER_PREFIX) begin
                        next_state = S_CHECK_FF;
                    end else begin
                        load       = 1'b1;
                        next_state = S_SHIFT;
                    end
                end
            end
            S_CHECK_FF: begin
                if (take) begin
                    if (byte_in == STUFF_BYTE) begin
                        load       = 1'b1;
                        load_data  = MARKER_PREFIX;
                        next_state = S_SHIFT;
                    end else if (byte_in == MARKER_PREFIX) begin
                        next_state = S_CHECK_FF;
                    end else if (is_rst_marker(byte_in)) begin
                        mark       = 1'b1;
                        mark_rst   = 1'b1;
                        next_state = S_FETCH;
                    end else if (byte_in == EOI) begin
                        mark       = 1'b1;
                        set_done   = 1'b1;
                        next_state = S_DONE;
                    end else begin
                        set_err    = 1'b1;
                        next_state = S_ERROR;
                    end
                end
            end
            S_SHIFT: begin
                if (emit && ser_last) next_state = S_FETCH;
            end
            S_DONE:  next_state = S_DONE;
            S_ERROR: next_state = S_ERROR;
            default: next_state = S_FETCH;
        endcase
    end

    bit_serializer u_ser (
        .clk   (clk_in),
        .rst   (rst_in),
        .load  (load),
        .data  (load_data),
        .shift (emit),
        .msb   (ser_msb),
        .last  (ser_last)
    );

    assign serial_out       = ser_msb;
    assign serial_valid_out = emit;

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            byte_ready_out   <= 1'b0;
            marker_valid_out <= 1'b0;
            dec_rst_out      <= 1'b0;
            marker_out       <= '0;
            done_out         <= 1'b0;
            error_out        <= 1'b0;
            blocks_out       <= '0;
        end else begin
            byte_ready_out   <= (next_state == S_FETCH) || (next_state == S_CHECK_FF);
            marker_valid_out <= mark;
            dec_rst_out      <= mark_rst;
            if (mark)     marker_out <= byte_in;
            if (set_done) done_out   <= 1'b1;
            if (set_err)  error_out  <= 1'b1;
            if (dec_valid_in && dec_dc_in) blocks_out <= blocks_out + CNT_W'(1);
        end
    end

`ifdef HUFF_FEED_STATS_EN
    logic        stuffing;
    logic [23:0] bit_cnt;
    logic [15:0] stuff_cnt;

    assign stuffing = take && (state == S_CHECK_FF) && (byte_in == STUFF_BYTE);

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            bit_cnt   <= '0;
            stuff_cnt <= '0;
        end else begin
            if (emit)     bit_cnt   <= bit_cnt + 24'd1;
            if (stuffing) stuff_cnt <= stuff_cnt + 16'd1;
        end
    end

    assign bits_out    = bit_cnt;
    assign stuffed_out = stuff_cnt;
`else
    assign bits_out    = '0;
    assign stuffed_out = '0;
`endif

endmodule
